laser_score_checker: RTL and testbench

- Downstream companion to the two-circle laser-placement engine, sitting beside it in the same image loop.
- Snoops the same 40-point X/Y stream the engine loads and latches the engine's C1/C2 result on DONE.
- Independently counts how many of the 40 points each circle covers and how many their union covers, then hands the score to the host over a valid/ready handshake.
- Double-buffers the point store, so the next image can be captured while the previous one is scored.

---
 rtl/laser_score_checker.sv | 217 +++++++++++++++++++++
 tb/tb_laser_score_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/laser_score_checker.sv
// Independent scorer for the two-circle laser-placement engine: snoops the point
// stream into a double-buffered store and counts coverage of the engine's circles.
module laser_score_checker #(
    parameter int LANES = 4,
    parameter int R2    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    input  logic       DONE,
    output logic       SCORE_VALID,
    input  logic       SCORE_READY,
    output logic [5:0] SCORE,
    output logic [5:0] C1_CNT,
    output logic [5:0] C2_CNT,
    output logic       ERR_SHORT,
    output logic       ERR_OVERRUN
);

    localparam int NPTS   = 40;
    localparam int N_EVAL = NPTS / LANES;
    localparam int IDX_W  = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

    localparam logic [5:0]       NPTS_W   = 6'(NPTS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_EVAL - 1);
    localparam logic [8:0]       R2_W     = 9'(R2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             eval_bank_q, eval_bank_d;
    logic [5:0]       cap_cnt_q, cap_cnt_d;
    logic [3:0]       c1x_q, c1x_d, c1y_q, c1y_d;
    logic [3:0]       c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0]       score_q, score_d;
    logic [5:0]       c1_cnt_q, c1_cnt_d;
    logic [5:0]       c2_cnt_q, c2_cnt_d;
    logic             err_short_q, err_short_d;
    logic             err_overrun_q, err_overrun_d;
    logic [7:0]       bank_q [2][NPTS];
    logic [7:0]       bank_d [2][NPTS];

    logic             done_accept;
    logic [5:0]       c1_add, c2_add, un_add;
    logic [5:0]       pidx;
    logic [7:0]       pt;
    logic             in1, in2;

    // Differences are taken in 5-bit signed so a far point never aliases to a near one.
    function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] diff;
        logic [3:0]        mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[4] ? 4'(-diff) : diff[3:0];
        return {4'b0, mag} * {4'b0, mag};
    endfunction

    function automatic logic point_inside(input logic [3:0] px, input logic [3:0] py,
                                          input logic [3:0] cx, input logic [3:0] cy);
        logic [8:0] d2;
        d2 = {1'b0, sq_diff(px, cx)} + {1'b0, sq_diff(py, cy)};
        return d2 <= R2_W;
    endfunction

    assign done_accept = DONE && (state_q == ST_IDLE);

    always_comb begin
        bank_d    = bank_q;
        cap_cnt_d = cap_cnt_q;
        wr_bank_d = wr_bank_q;
        if (done_accept) begin
            cap_cnt_d = '0;
            wr_bank_d = ~wr_bank_q;
        end else if (cap_cnt_q < NPTS_W) begin
            bank_d[wr_bank_q][cap_cnt_q] = {X, Y};
            cap_cnt_d                    = cap_cnt_q + 6'd1;
        end
    end

    always_comb begin
        c1_add = '0;
        c2_add = '0;
        un_add = '0;
        pidx   = '0;
        pt     = '0;
        in1    = 1'b0;
        in2    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            pidx   = 6'(int'(idx_q) * LANES + l);
            pt     = bank_q[eval_bank_q][pidx];
            in1    = point_inside(pt[7:4], pt[3:0], c1x_q, c1y_q);
            in2    = point_inside(pt[7:4], pt[3:0], c2x_q, c2y_q);
            c1_add = c1_add + {5'b0, in1};
            c2_add = c2_add + {5'b0, in2};
            un_add = un_add + {5'b0, in1 | in2};
        end
    end

    // A DONE that arrives while a score is still being built or held is only flagged.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        eval_bank_d   = eval_bank_q;
        c1x_d         = c1x_q;
        c1y_d         = c1y_q;
        c2x_d         = c2x_q;
        c2y_d         = c2y_q;
        score_d       = score_q;
        c1_cnt_d      = c1_cnt_q;
        c2_cnt_d      = c2_cnt_q;
        err_short_d   = err_short_q;
        err_overrun_d = err_overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (DONE) begin
                    c1x_d       = C1X;
                    c1y_d       = C1Y;
                    c2x_d       = C2X;
                    c2y_d       = C2Y;
                    eval_bank_d = wr_bank_q;
                    idx_d       = '0;
                    score_d     = '0;
                    c1_cnt_d    = '0;
                    c2_cnt_d    = '0;
                    if (cap_cnt_q < NPTS_W) begin
                        err_short_d = 1'b1;
                    end
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (DONE) begin
                    err_overrun_d = 1'b1;
                end
                score_d  = score_q + un_add;
                c1_cnt_d = c1_cnt_q + c1_add;
                c2_cnt_d = c2_cnt_q + c2_add;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (DONE) begin
                    err_overrun_d = 1'b1;
                end
                if (SCORE_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            wr_bank_q     <= 1'b0;
            eval_bank_q   <= 1'b0;
            cap_cnt_q     <= '0;
            c1x_q         <= '0;
            c1y_q         <= '0;
            c2x_q         <= '0;
            c2y_q         <= '0;
            score_q       <= '0;
            c1_cnt_q      <= '0;
            c2_cnt_q      <= '0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPTS; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_bank_q     <= wr_bank_d;
            eval_bank_q   <= eval_bank_d;
            cap_cnt_q     <= cap_cnt_d;
            c1x_q         <= c1x_d;
            c1y_q         <= c1y_d;
            c2x_q         <= c2x_d;
            c2y_q         <= c2y_d;
            score_q       <= score_d;
            c1_cnt_q      <= c1_cnt_d;
            c2_cnt_q      <= c2_cnt_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
            bank_q        <= bank_d;
        end
    end

    assign SCORE_VALID = (state_q == ST_HOLD);
    assign SCORE       = score_q;
    assign C1_CNT      = c1_cnt_q;
    assign C2_CNT      = c2_cnt_q;
    assign ERR_SHORT   = err_short_q;
    assign ERR_OVERRUN = err_overrun_q;

endmodule

// File: tb/tb_laser_score_checker.sv
// Scoreboard bench for laser_score_checker: directed images push their hand-worked
// scores, and a negedge monitor compares every cycle the score is presented.
module tb_laser_score_checker;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] X = '0, Y = '0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic       DONE = 1'b0;
    logic       SCORE_READY = 1'b0;
    logic       SCORE_VALID;
    logic [5:0] SCORE, C1_CNT, C2_CNT;
    logic       ERR_SHORT, ERR_OVERRUN;

    typedef struct {
        int score;
        int c1;
        int c2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] px [40];
    logic [3:0] py [40];

    laser_score_checker dut (
        .CLK(CLK), .RST(RST), .X(X), .Y(Y),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .DONE(DONE), .SCORE_VALID(SCORE_VALID), .SCORE_READY(SCORE_READY),
        .SCORE(SCORE), .C1_CNT(C1_CNT), .C2_CNT(C2_CNT),
        .ERR_SHORT(ERR_SHORT), .ERR_OVERRUN(ERR_OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Scoreboard monitor: every presented cycle is compared, so a held score must stay stable.
    always @(negedge CLK) begin
        if (!RST && SCORE_VALID) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_score: got SCORE=%0d with no expectation queued", SCORE);
            end else begin
                checkOutput("score", int'(SCORE), sb[0].score);
                checkOutput("c1_cnt", int'(C1_CNT), sb[0].c1);
                checkOutput("c2_cnt", int'(C2_CNT), sb[0].c2);
                if (SCORE_READY) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fillPattern(input int id);
        for (int i = 0; i < 40; i++) begin
            case (id)
                0: begin px[i] = 4'd8; py[i] = 4'd8; end
                1, 2, 3: begin
                    px[i] = (i < 20) ? 4'd2 : 4'd13;
                    py[i] = (i < 20) ? 4'd2 : 4'd13;
                end
                4: begin px[i] = 4'd5; py[i] = 4'd5; end
                5: begin
                    px[i] = (i < 20) ? 4'd15 : 4'd2;
                    py[i] = (i < 20) ? 4'd15 : 4'd2;
                end
                default: begin px[i] = 4'(i % 16); py[i] = 4'd8; end
            endcase
        end
        if (id == 2) begin px[0] = 4'd6; py[0] = 4'd2; end
        if (id == 3) begin px[0] = 4'd7; py[0] = 4'd2; end
    endtask

    task automatic sendPoints(input int n);
        for (int i = 0; i < n; i++) begin
            X = px[i];
            Y = py[i];
            tick();
        end
    endtask

    task automatic pulseDone(input int c1x, input int c1y, input int c2x, input int c2y);
        C1X  = 4'(c1x);
        C1Y  = 4'(c1y);
        C2X  = 4'(c2x);
        C2Y  = 4'(c2y);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
    endtask

    task automatic watchLatency();
        int n;
        n = 1;
        while (!SCORE_VALID && n < 40) begin
            tick();
            n++;
        end
        checkOutput("latency", n, 11);
    endtask

    task automatic acceptScore();
        SCORE_READY = 1'b1;
        tick();
        SCORE_READY = 1'b0;
        checkOutput("valid_after_accept", int'(SCORE_VALID), 0);
    endtask

    task automatic resetDut();
        RST  = 1'b1;
        DONE = 1'b0;
        SCORE_READY = 1'b0;
        repeat (3) tick();
        checkOutput("rst_valid", int'(SCORE_VALID), 0);
        checkOutput("rst_score", int'(SCORE), 0);
        checkOutput("rst_c1", int'(C1_CNT), 0);
        checkOutput("rst_c2", int'(C2_CNT), 0);
        checkOutput("rst_err_short", int'(ERR_SHORT), 0);
        checkOutput("rst_err_overrun", int'(ERR_OVERRUN), 0);
        RST = 1'b0;
    endtask

    // One image: score the captured bank while the next image streams in, score held for ~30 cycles.
    task automatic applyStimulus(input int next_id, input int c1x, input int c1y,
                                 input int c2x, input int c2y,
                                 input int e_score, input int e_c1, input int e_c2);
        exp_t e;
        e.score = e_score;
        e.c1    = e_c1;
        e.c2    = e_c2;
        sb.push_back(e);
        pulseDone(c1x, c1y, c2x, c2y);
        fillPattern(next_id);
        fork
            sendPoints(40);
            watchLatency();
        join
        acceptScore();
        checkOutput("err_short_clean", int'(ERR_SHORT), 0);
        checkOutput("err_overrun_clean", int'(ERR_OVERRUN), 0);
    endtask

    initial begin
        exp_t e;
        resetDut();
        fillPattern(0);
        sendPoints(40);
        applyStimulus(1, 8, 8, 0, 0, 40, 40, 0);
        applyStimulus(2, 2, 2, 13, 13, 40, 20, 20);
        applyStimulus(3, 2, 2, 13, 13, 40, 20, 20);
        applyStimulus(4, 2, 2, 13, 13, 39, 19, 20);
        applyStimulus(5, 3, 5, 7, 5, 40, 40, 40);
        applyStimulus(6, 0, 0, 15, 15, 40, 20, 20);
        applyStimulus(0, 4, 8, 12, 8, 40, 26, 16);

        // Short image: 30 samples of (8,8); the rest of bank 0 still holds cleared (0,0) entries.
        resetDut();
        fillPattern(0);
        sendPoints(30);
        e.score = 40;
        e.c1    = 30;
        e.c2    = 10;
        sb.push_back(e);
        pulseDone(8, 8, 0, 0);
        fillPattern(6);
        fork
            sendPoints(40);
            watchLatency();
        join
        checkOutput("err_short_set", int'(ERR_SHORT), 1);
        checkOutput("err_overrun_idle", int'(ERR_OVERRUN), 0);
        pulseDone(0, 0, 15, 15);
        checkOutput("err_overrun_set", int'(ERR_OVERRUN), 1);
        checkOutput("valid_after_overrun", int'(SCORE_VALID), 1);
        repeat (3) tick();
        acceptScore();
        checkOutput("err_short_sticky", int'(ERR_SHORT), 1);
        checkOutput("err_overrun_sticky", int'(ERR_OVERRUN), 1);

        // Bank 1 now holds pattern 6; reset after four evaluation groups (points 0..15).
        pulseDone(4, 8, 12, 8);
        repeat (4) tick();
        checkOutput("partial_c1", int'(C1_CNT), 9);
        checkOutput("partial_c2", int'(C2_CNT), 8);
        checkOutput("partial_score", int'(SCORE), 16);
        RST = 1'b1;
        tick();
        checkOutput("midrst_valid", int'(SCORE_VALID), 0);
        checkOutput("midrst_score", int'(SCORE), 0);
        checkOutput("midrst_c1", int'(C1_CNT), 0);
        checkOutput("midrst_c2", int'(C2_CNT), 0);
        checkOutput("midrst_err_short", int'(ERR_SHORT), 0);
        checkOutput("midrst_err_overrun", int'(ERR_OVERRUN), 0);
        RST = 1'b0;
        fillPattern(3);
        sendPoints(40);
        applyStimulus(0, 2, 2, 13, 13, 39, 19, 20);

        repeat (3) tick();
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
